// File: rtl/rom_sw_reader.sv
// Sample-ROM playback engine: walks addresses 0..DEPTH-1 for a number of passes and
// streams each sample, arithmetically right-shifted, through a 2-entry output FIFO.
//
// state | meaning
// IDLE  | waiting for start, rom_addr parked at 0, no output
// FETCH | issuing ROM reads whenever FIFO credit allows
// DRAIN | every read issued, emptying in-flight read and FIFO
module rom_sw_reader #(
  parameter int DEPTH = 401,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [7:0]           loops,
  input  logic [4:0]           shift,
  output logic [AW-1:0]        rom_addr,
  input  logic signed [DW-1:0] rom_dout,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t r_state, w_state_nxt;
  logic   r_done, w_done_nxt;

  logic [AW-1:0]        r_addr;
  logic [7:0]           r_pass;
  logic                 r_cont;
  logic [4:0]           r_shift;
  logic                 r_inflight;
  logic                 r_infl_last;
  logic signed [DW-1:0] r_fifo_data [2];
  logic [1:0]           r_fifo_last;
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_count;

  logic                 w_start;
  logic                 w_stop;
  logic                 w_pop;
  logic                 w_push;
  logic [2:0]           w_occ;
  logic                 w_at_end;
  logic                 w_final;
  logic                 w_issue;
  logic signed [DW-1:0] w_scaled;

  assign w_start  = (r_state == IDLE) && start;
  assign w_stop   = (r_state != IDLE) && stop;
  assign w_pop    = (r_count != 2'd0) && out_ready && !w_stop;
  assign w_push   = r_inflight && !w_stop;
  // Credit counts the slot freed by a same-cycle pop so a stream of
  // back-to-back transfers keeps one read in flight every cycle.
  assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_at_end = (r_addr == AW'(DEPTH - 1));
  assign w_final  = !r_cont && (r_pass == 8'd1);
  assign w_issue  = (r_state == FETCH) && !stop && (w_occ < 3'd2);
  assign w_scaled = rom_dout >>> r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_issue && w_at_end && w_final) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (!r_inflight &&
                     (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_pass      <= '0;
      r_cont      <= 1'b0;
      r_shift     <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_fifo_last <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= '0;
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= '0;
        r_pass  <= loops;
        r_cont  <= (loops == 8'd0);
        r_shift <= shift;
      end else if (w_stop) begin
        r_addr <= '0;
      end else if (w_issue) begin
        if (w_at_end) begin
          r_addr <= '0;
          if (!r_cont) r_pass <= r_pass - 8'd1;
        end else begin
          r_addr <= r_addr + AW'(1);
        end
      end

      r_inflight  <= w_issue;
      r_infl_last <= w_issue && w_at_end && w_final;

      if (w_stop) begin
        r_count     <= '0;
        r_rd_ptr    <= 1'b0;
        r_wr_ptr    <= 1'b0;
        r_fifo_last <= '0;
      end else begin
        if (w_push) begin
          r_fifo_data[r_wr_ptr] <= w_scaled;
          r_fifo_last[r_wr_ptr] <= r_infl_last;
          r_wr_ptr              <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign rom_addr  = r_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_last  = out_valid && r_fifo_last[r_rd_ptr];
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_rom_sw_reader.sv
// Scoreboard bench for rom_sw_reader: a registered ROM model feeds the DUT, expected
// samples are queued at stimulus time and a negedge monitor pops and compares transfers.
module tb_rom_sw_reader;
  localparam int DEPTH = 401;
  localparam int AW    = 9;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [7:0]    loops = '0;
  logic [4:0]    shift = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  rom_sw_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loops(loops), .shift(shift),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            xfer_idx = 0;
  int            last_cnt = 0;
  int            last_idx = -1;
  int            last_xfer_cyc = 0;
  int            n_done = 0;
  int            done_cyc = 0;
  int            rdy_mode = 0;
  int            tr_data [0:1023];
  logic [DW-1:0] rom_mem [0:511];

  // ROM contents: fixed reference points, pseudo-random mixed-sign filler elsewhere
  initial begin
    for (int k = 0; k < 512; k++) begin
      if (k < DEPTH) rom_mem[k] = (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
      else           rom_mem[k] = '0;
    end
    rom_mem[0]   = 32'sd0;
    rom_mem[1]   = 32'sd485243364;
    rom_mem[11]  = -32'sd311543726;
    rom_mem[399] = -32'sd485243364;
    rom_mem[400] = 32'sd0;
  end

  initial forever begin
    @(posedge clk);
    rom_dout <= rom_mem[rom_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int pn;
    pn = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: begin
          out_ready = (pn < 40) ? (pn % 2 == 0) : ($urandom_range(0, 3) != 0);
          pn++;
        end
      endcase
      if (rdy_mode != 2) pn = 0;
    end
  end

  // Monitor: scoreboard pop on every transfer, plus hold check across stalls
  initial begin
    exp_t          e;
    bit            prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!(out_valid === 1'b1 && out_data === prev_d && out_last === prev_l)) begin
          failures++;
          $display("FAIL stall_hold actual valid=%0b data=%0d last=%0b required valid=1 data=%0d last=%0b",
                   out_valid, $signed(out_data), out_last, $signed(prev_d), prev_l);
        end
      end
      prev_stall = out_valid && !out_ready && !rst && !stop;
      prev_d = out_data;
      prev_l = out_last;
      if (!rst && !stop && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected idx=%0d actual data=%0d required no transfer",
                   xfer_idx, $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            failures++;
            $display("FAIL sb_data idx=%0d actual data=%0d last=%0b required data=%0d last=%0b",
                     xfer_idx, $signed(out_data), out_last, $signed(e.d), e.l);
          end
        end
        if (xfer_idx < 1024) tr_data[xfer_idx] = $signed(out_data);
        if (out_last) begin
          last_cnt++;
          last_idx = xfer_idx;
        end
        xfer_idx++;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_passes(input int n, input int sh, input bit last_on_final);
    exp_t e;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        e.d = $signed(rom_mem[k]) >>> sh;
        e.l = last_on_final && (p == n - 1) && (k == DEPTH - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input int l, input int sh);
    @(posedge clk);
    #1;
    loops = 8'(l);
    shift = 5'(sh);
    start = 1'b1;
    xfer_idx = 0;
    last_cnt = 0;
    last_idx = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("lat_e0_valid", out_valid, 0);
    chk("lat_e0_busy", busy, 1);
    chk("lat_e0_addr", rom_addr, 0);
    @(posedge clk);
    #1;
    chk("lat_e1_valid", out_valid, 0);
    chk("lat_e1_addr", rom_addr, 1);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", out_valid, 1);
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) chk({name, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    chk({name, "_done_width"}, done, 0);
  endtask

  task automatic wait_xfers(input int target, input int max_cyc, input string name);
    int n;
    n = 0;
    while (xfer_idx < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_xfer_reached"}, (xfer_idx >= target), 1);
  endtask

  task automatic end_checks(input string name, input int n0, input int nx, input int li);
    chk({name, "_xfers"}, xfer_idx, nx);
    chk({name, "_last_cnt"}, last_cnt, 1);
    chk({name, "_last_idx"}, last_idx, li);
    chk({name, "_done_cyc"}, done_cyc, last_xfer_cyc + 1);
    chk({name, "_done_cnt"}, n_done - n0, 1);
    chk({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", rom_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // single pass, no scaling
    n0 = n_done;
    push_passes(1, 0, 1'b1);
    do_start(1, 0);
    wait_done(1000, "t1");
    end_checks("t1", n0, 401, 400);
    chk("t1_s1", tr_data[1], 485243364);
    chk("t1_s11", tr_data[11], -311543726);
    chk("t1_s399", tr_data[399], -485243364);
    chk("t1_s400", tr_data[400], 0);

    // shift by 4
    n0 = n_done;
    push_passes(1, 4, 1'b1);
    do_start(1, 4);
    wait_done(1000, "t2");
    end_checks("t2", n0, 401, 400);
    chk("t2_s0", tr_data[0], 0);
    chk("t2_s1", tr_data[1], 30327710);
    chk("t2_s11", tr_data[11], -19471483);

    // shift by 31 collapses to sign
    n0 = n_done;
    push_passes(1, 31, 1'b1);
    do_start(1, 31);
    wait_done(1000, "t2b");
    end_checks("t2b", n0, 401, 400);
    chk("t2b_s1", tr_data[1], 0);
    chk("t2b_s11", tr_data[11], -1);
    chk("t2b_s399", tr_data[399], -1);

    // alternating then random backpressure
    n0 = n_done;
    rdy_mode = 2;
    push_passes(1, 0, 1'b1);
    do_start(1, 0);
    wait_done(5000, "t3");
    end_checks("t3", n0, 401, 400);
    rdy_mode = 0;

    // two passes, with a start pulse mid-run that must be ignored
    n0 = n_done;
    push_passes(2, 0, 1'b1);
    do_start(2, 0);
    wait_xfers(100, 500, "t4");
    @(posedge clk);
    #1;
    loops = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3000, "t4");
    end_checks("t4", n0, 802, 801);
    chk("t4_s401", tr_data[401], 0);
    chk("t4_s402", tr_data[402], 485243364);

    // continuous playback aborted by stop
    n0 = n_done;
    push_passes(3, 0, 1'b0);
    do_start(0, 0);
    wait_xfers(1000, 3000, "t5");
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk("t5_valid_after_stop", out_valid, 0);
    chk("t5_done_after_stop", done, 1);
    chk("t5_busy_after_stop", busy, 0);
    chk("t5_addr_after_stop", rom_addr, 0);
    @(posedge clk);
    #1;
    chk("t5_done_width", done, 0);
    chk("t5_done_cnt", n_done - n0, 1);
    chk("t5_last_cnt", last_cnt, 0);
    exp_q.delete();

    // reset during a stall mid-pass, then replay
    n0 = n_done;
    push_passes(1, 0, 1'b1);
    do_start(1, 0);
    wait_xfers(50, 500, "t6");
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_addr", rom_addr, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_last", out_last, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", n_done - n0, 0);
    exp_q.delete();
    rdy_mode = 0;
    n0 = n_done;
    push_passes(1, 0, 1'b1);
    do_start(1, 0);
    wait_done(1000, "t6r");
    end_checks("t6r", n0, 401, 400);
    chk("t6r_s0", tr_data[0], 0);
    chk("t6r_s1", tr_data[1], 485243364);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
